// File: rtl/multi_mac_matcher.sv
// Streaming multi-pattern byte matcher: finds up to NUM_PAT byte patterns at any lane/beat
// alignment (or only at frame offset 0), keeps sticky match flags, and forwards a delayed copy of the stream.
module multi_mac_matcher #(
   parameter int BYTES     = 4,
   parameter int PAT_BYTES = 6,
   parameter int NUM_PAT   = 4,
   parameter int DELAY     = 3,
   localparam int ID_W     = $clog2(NUM_PAT)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear,
   input  logic                           in_valid,
   input  logic [8*BYTES-1:0]             data_in,
   input  logic                           anchored,
   input  logic [NUM_PAT-1:0]             pat_en,
   input  logic [NUM_PAT*8*PAT_BYTES-1:0] patterns,
   output logic                           out_valid,
   output logic [8*BYTES-1:0]             data_out,
   output logic                           match,
   output logic [NUM_PAT-1:0]             match_vec,
   output logic [ID_W-1:0]                match_id
);

   // History keeps the last PAT_BYTES-1 bytes: enough for a window ending at lane 0 of the new beat.
   localparam int HB   = PAT_BYTES - 1;
   localparam int SB   = HB + BYTES;
   localparam int FMAX = PAT_BYTES + BYTES;
   localparam int FC_W = $clog2(FMAX + 1);

   logic [8*HB-1:0]        hist_reg;
   logic [FC_W-1:0]        fcnt_reg;
   logic [NUM_PAT-1:0]     match_vec_reg;
   logic [ID_W-1:0]        match_id_reg;
   logic                   match_reg;

   logic [FC_W-1:0]        fcnt_eff;
   logic [FC_W:0]          fcnt_sum;
   logic [FC_W-1:0]        fcnt_next;
   logic [8*SB-1:0]        stream;
   logic [BYTES-1:0]       win_ok;
   logic [8*PAT_BYTES-1:0] win      [BYTES];
   logic [8*PAT_BYTES-1:0] pat_wire [NUM_PAT];
   logic [BYTES-1:0]       lane_hit [NUM_PAT];
   logic [NUM_PAT-1:0]     hits;
   logic [NUM_PAT-1:0]     match_vec_next;
   logic [ID_W-1:0]        match_id_next;

   // A clear on the same cycle as a beat makes that beat offset 0 with no usable history.
   assign fcnt_eff  = clear ? '0 : fcnt_reg;
   assign stream    = {data_in, (clear ? {8*HB{1'b0}} : hist_reg)};
   assign fcnt_sum  = {1'b0, fcnt_eff} + (FC_W+1)'(BYTES);
   assign fcnt_next = (fcnt_sum >= (FC_W+1)'(FMAX)) ? FC_W'(FMAX) : fcnt_sum[FC_W-1:0];

   genvar gi, gj;

   // Byte-reverse each pattern so its first wire byte sits in the low byte, like the stream.
   generate
      for (gi = 0; gi < NUM_PAT; gi++) begin : g_pat
         for (gj = 0; gj < PAT_BYTES; gj++) begin : g_pbyte
            assign pat_wire[gi][gj*8 +: 8] = patterns[gi*8*PAT_BYTES + (PAT_BYTES-1-gj)*8 +: 8];
         end
      end
   endgenerate

   // Window ending at lane gi starts at frame offset fcnt_eff + gi - (PAT_BYTES-1).
   generate
      for (gi = 0; gi < BYTES; gi++) begin : g_win
         assign win[gi]    = stream[gi*8 +: 8*PAT_BYTES];
         assign win_ok[gi] = anchored ? (int'(fcnt_eff) + gi == HB)
                                      : (int'(fcnt_eff) + gi >= HB);
      end
   endgenerate

   generate
      for (gi = 0; gi < NUM_PAT; gi++) begin : g_hit
         for (gj = 0; gj < BYTES; gj++) begin : g_lane
            assign lane_hit[gi][gj] = win_ok[gj] && (win[gj] == pat_wire[gi]);
         end
         assign hits[gi] = in_valid && pat_en[gi] && (|lane_hit[gi]);
      end
   endgenerate

   assign match_vec_next = (clear ? '0 : match_vec_reg) | hits;

   always_comb begin
      match_id_next = '0;
      for (int i = NUM_PAT - 1; i >= 0; i--) begin
         if (match_vec_next[i]) match_id_next = ID_W'(i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_reg      <= '0;
         fcnt_reg      <= '0;
         match_vec_reg <= '0;
         match_id_reg  <= '0;
         match_reg     <= 1'b0;
      end else begin
         if (in_valid) begin
            hist_reg <= stream[8*SB-1 -: 8*HB];
            fcnt_reg <= fcnt_next;
         end else if (clear) begin
            hist_reg <= '0;
            fcnt_reg <= '0;
         end
         match_vec_reg <= match_vec_next;
         match_id_reg  <= match_id_next;
         match_reg     <= |match_vec_next;
      end
   end

   assign match_vec = match_vec_reg;
   assign match_id  = match_id_reg;
   assign match     = match_reg;

   // Delay line shifts every cycle regardless of clear or matching.
   logic [8*BYTES:0] dly_reg [DELAY];

   generate
      for (gi = 0; gi < DELAY; gi++) begin : g_dly
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or posedge rst) begin
               if (rst) dly_reg[0] <= '0;
               else     dly_reg[0] <= {in_valid, data_in};
            end
         end else begin : g_next
            always_ff @(posedge clk or posedge rst) begin
               if (rst) dly_reg[gi] <= '0;
               else     dly_reg[gi] <= dly_reg[gi-1];
            end
         end
      end
   endgenerate

   assign out_valid = dly_reg[DELAY-1][8*BYTES];
   assign data_out  = dly_reg[DELAY-1][8*BYTES-1:0];

endmodule

// File: tb/tb_multi_mac_matcher.sv
// Directed bench for multi_mac_matcher with default parameters (4-byte beats, 6-byte patterns).
module tb_multi_mac_matcher;

   localparam logic [47:0] P0 = 48'h01B2C3D4E5F6;
   localparam logic [47:0] P1 = 48'h111111111111;
   localparam logic [47:0] P2 = 48'h222222222222;
   localparam logic [47:0] P3 = 48'h333333333333;

   logic         clk = 1'b0;
   logic         rst, clear, in_valid, anchored;
   logic [31:0]  data_in, data_out;
   logic [3:0]   pat_en, match_vec;
   logic [191:0] patterns;
   logic         out_valid, match;
   logic [1:0]   match_id;

   int checks = 0;
   int errors = 0;

   multi_mac_matcher dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .data_in(data_in),
      .anchored(anchored), .pat_en(pat_en), .patterns(patterns),
      .out_valid(out_valid), .data_out(data_out), .match(match),
      .match_vec(match_vec), .match_id(match_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk_match(input string tag, input logic [3:0] vec, input logic [1:0] id);
      chk({tag, "_vec"}, 64'(match_vec), 64'(vec));
      chk({tag, "_match"}, 64'(match), 64'(vec != 4'b0000));
      chk({tag, "_id"}, 64'(match_id), 64'(id));
   endtask

   task automatic beat(input logic [31:0] d);
      in_valid = 1'b1;
      data_in  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic do_clear();
      clear    = 1'b1;
      in_valid = 1'b0;
      tick();
      clear    = 1'b0;
   endtask

   task automatic run_seq(input string tag, input bit anch, input int n,
                          input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                          input logic [3:0] exp_vec, input logic [1:0] exp_id);
      logic [31:0] bs [3];
      bs[0] = b0; bs[1] = b1; bs[2] = b2;
      do_clear();
      anchored = anch;
      for (int i = 0; i < n; i++) begin
         beat(bs[i]);
         if (i < n - 1) chk_match($sformatf("%s_mid%0d", tag, i), 4'b0000, 2'd0);
         else           chk_match(tag, exp_vec, exp_id);
      end
      $display("seq %s anchored=%0d beats=%0d match_vec=%b match_id=%0d", tag, anch, n, match_vec, match_id);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; data_in = '0; anchored = 1'b0;
      pat_en = 4'b0001;
      patterns = {P3, P2, P1, P0};
      tick(); tick();
      chk_match("reset", 4'b0000, 2'd0);
      chk("reset_ov", 64'(out_valid), 64'd0);
      chk("reset_dout", 64'(data_out), 64'd0);
      rst = 1'b0;
      $display("reset released");

      // Aligned pattern, anchored
      anchored = 1'b1;
      beat(32'hD4C3B201);
      chk_match("al_b1", 4'b0000, 2'd0);
      beat(32'h0000F6E5);
      chk_match("al_b2", 4'b0001, 2'd0);
      idle();
      chk("al_dout1", 64'(data_out), 64'h00000000D4C3B201);
      chk("al_ov1", 64'(out_valid), 64'd1);
      idle();
      chk("al_dout2", 64'(data_out), 64'h000000000000F6E5);
      idle();
      chk("al_ov_end", 64'(out_valid), 64'd0);
      $display("aligned match_vec=%b data_out=%h", match_vec, data_out);

      // Asynchronous reset mid-frame
      beat(32'hD4C3B201);
      rst = 1'b1;
      #1;
      chk_match("rst_mid", 4'b0000, 2'd0);
      chk("rst_mid_dout", 64'(data_out), 64'd0);
      rst = 1'b0;
      #1;
      anchored = 1'b0;
      beat(32'h0000F6E5);
      chk_match("rst_partial", 4'b0000, 2'd0);
      $display("mid-frame reset match_vec=%b", match_vec);

      // Shifted patterns, free and anchored
      run_seq("sh1", 1'b0, 2, 32'hC3B20100, 32'h00F6E5D4, 32'h0, 4'b0001, 2'd0);
      run_seq("sh2", 1'b0, 2, 32'hB2010000, 32'hF6E5D4C3, 32'h0, 4'b0001, 2'd0);
      run_seq("sh3", 1'b0, 3, 32'h01000000, 32'hE5D4C3B2, 32'h000000F6, 4'b0001, 2'd0);
      run_seq("sh1a", 1'b1, 2, 32'hC3B20100, 32'h00F6E5D4, 32'h0, 4'b0000, 2'd0);
      run_seq("sh2a", 1'b1, 2, 32'hB2010000, 32'hF6E5D4C3, 32'h0, 4'b0000, 2'd0);
      run_seq("sh3a", 1'b1, 3, 32'h01000000, 32'hE5D4C3B2, 32'h000000F6, 4'b0000, 2'd0);

      // Multi-pattern, idle gap holds history, pat_en does not clear flags
      patterns = {P3, P0, P1, P0};
      pat_en = 4'b0101;
      do_clear();
      anchored = 1'b0;
      beat(32'hD4C3B201);
      idle();
      chk_match("mp_gap", 4'b0000, 2'd0);
      beat(32'h0000F6E5);
      chk_match("mp_0101", 4'b0101, 2'd0);
      pat_en = 4'b0000;
      beat(32'hD4C3B201);
      chk_match("mp_hold", 4'b0101, 2'd0);
      pat_en = 4'b0100;
      run_seq("mp_0100", 1'b0, 2, 32'hD4C3B201, 32'h0000F6E5, 32'h0, 4'b0100, 2'd2);

      // Clear boundary
      patterns = {P3, P2, P1, P0};
      pat_en = 4'b0001;
      do_clear();
      chk_match("clr_zero", 4'b0000, 2'd0);
      beat(32'hC3B20100);
      do_clear();
      beat(32'h00F6E5D4);
      beat(32'h00000000);
      chk_match("clr_split", 4'b0000, 2'd0);
      do_clear();
      beat(32'hC3B20100);
      clear = 1'b1;
      beat(32'h00F6E5D4);
      clear = 1'b0;
      beat(32'h00000000);
      chk_match("clr_split_same", 4'b0000, 2'd0);
      run_seq("clr_pre", 1'b0, 2, 32'hD4C3B201, 32'h0000F6E5, 32'h0, 4'b0001, 2'd0);
      anchored = 1'b1;
      clear = 1'b1;
      beat(32'hD4C3B201);
      clear = 1'b0;
      chk_match("clr_valid_b1", 4'b0000, 2'd0);
      beat(32'h0000F6E5);
      chk_match("clr_valid_b2", 4'b0001, 2'd0);
      $display("clear boundary match_vec=%b", match_vec);

      // All-ones and all-zero patterns
      patterns = {P3, P2, 48'hFFFFFFFFFFFF, P0};
      pat_en = 4'b0011;
      run_seq("ones", 1'b0, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'b0010, 2'd1);
      patterns = {48'h0, 48'h0, 48'hFFFFFFFFFFFF, P0};
      pat_en = 4'b1001;
      run_seq("zeros", 1'b0, 2, 32'h00000000, 32'h00000000, 32'h0, 4'b1000, 2'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
